// File: rtl/hsdaoh_fifo_scheduler_pkg.sv
// Shared types and constants for the hsdaoh FIFO write scheduler.
// The ST_TRAILER state exists only when SCHED_CHECKSUM_EN is defined.
package hsdaoh_sched_pkg;

    localparam int DATA_W  = 16;
    localparam int MAGIC_W = 4;
    localparam int ID_W    = 4;
    localparam int SEQ_W   = 8;

    localparam logic [MAGIC_W-1:0] HDR_MAGIC = 4'hA;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_HEADER  = 2'd1,
        ST_BURST   = 2'd2
`ifdef SCHED_CHECKSUM_EN
        ,ST_TRAILER = 2'd3
`endif
    } sched_state_e;

    function automatic logic [DATA_W-1:0] make_header(input logic [ID_W-1:0]  id,
                                                      input logic [SEQ_W-1:0] seq);
        return {HDR_MAGIC, id, seq};
    endfunction

endpackage

// File: rtl/hsdaoh_fifo_scheduler_if.sv
// Source-side and FIFO-side signals of the scheduler; master is the scheduler,
// slave is the environment (sources plus FIFO write port).
interface hsdaoh_fifo_scheduler_if #(
    parameter int NUM_SRC = 2
);
    import hsdaoh_sched_pkg::*;

    logic                      enable;
    logic [NUM_SRC-1:0]        src_valid;
    logic [DATA_W*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      fifo_afull;
    logic                      fifo_full;
    logic                      fifo_winc;
    logic [DATA_W-1:0]         fifo_wdata;
    logic [ID_W-1:0]           grant_id;
    logic [15:0]               drop_cnt;
    logic                      ovf_err;

    modport master (
        input  enable, src_valid, src_data, fifo_afull, fifo_full,
        output src_ready, fifo_winc, fifo_wdata, grant_id, drop_cnt, ovf_err
    );

    modport slave (
        output enable, src_valid, src_data, fifo_afull, fifo_full,
        input  src_ready, fifo_winc, fifo_wdata, grant_id, drop_cnt, ovf_err
    );

endinterface

// File: rtl/hsdaoh_fifo_scheduler_rr_arbiter.sv
// Combinational round-robin search: first requester after `last`, wrapping
// modulo NUM_SRC.
module rr_arbiter
    import hsdaoh_sched_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    logic [15:0] req_pad;
    logic [4:0]  idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_pad = 16'(req);
        gnt_id  = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            // last < NUM_SRC, so one conditional subtract implements the modulo
            idx = 5'(last) + 5'(k);
            if (idx >= 5'(NUM_SRC)) idx = idx - 5'(NUM_SRC);
            if (!any && req_pad[idx[3:0]]) begin
                any    = 1'b1;
                gnt_id = idx[3:0];
            end
        end
    end

endmodule

// File: rtl/hsdaoh_fifo_scheduler.sv
// Round-robin burst scheduler in front of the hsdaoh async FIFO write port.
// Define SCHED_CHECKSUM_EN to append a 16-bit payload-sum trailer to each burst.
module hsdaoh_fifo_scheduler
    import hsdaoh_sched_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int BURST_LEN = 256
) (
    input logic                     clk_data,
    input logic                     rst,
    hsdaoh_fifo_scheduler_if.master bus
);

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    grant_id_q, last_grant_q, arb_id;
    logic               arb_any;
    logic [SEQ_W-1:0]   seq_q;
    logic [15:0]        beat_q;
    logic [15:0]        drop_cnt_q;
    logic               ovf_err_q;
    logic               winc_q, winc_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [NUM_SRC-1:0] src_ready;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;
    logic               arb_go, hdr_wr, accept, last_beat, drop_any;
`ifdef SCHED_CHECKSUM_EN
    logic [DATA_W-1:0]  sum_q;
    logic               trl_wr;
`endif

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req    (bus.src_valid),
        .last   (last_grant_q),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_data  = bus.src_data[DATA_W*i +: DATA_W];
                sel_valid = bus.src_valid[i];
            end
        end
    end

    assign arb_go    = (state_q == ST_ARB) && bus.enable && !bus.fifo_afull && arb_any;
    assign hdr_wr    = (state_q == ST_HEADER) && !bus.fifo_afull;
    assign accept    = (state_q == ST_BURST) && sel_valid && !bus.fifo_afull;
    assign last_beat = accept && (beat_q == 16'(BURST_LEN - 1));
    assign drop_any  = |(bus.src_valid & ~src_ready);
`ifdef SCHED_CHECKSUM_EN
    assign trl_wr    = (state_q == ST_TRAILER) && !bus.fifo_afull;
`endif

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of process order.
    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) state_q <= ST_ARB;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:    if (arb_go) state_d = ST_HEADER;
            ST_HEADER: if (hdr_wr) state_d = ST_BURST;
`ifdef SCHED_CHECKSUM_EN
            ST_BURST:   if (last_beat) state_d = ST_TRAILER;
            ST_TRAILER: if (trl_wr)    state_d = ST_ARB;
`else
            ST_BURST:   if (last_beat) state_d = ST_ARB;
`endif
            default:   state_d = ST_ARB;
        endcase
    end

    // Ready is combinational so almost-full backpressure acts in the same cycle
    always_comb begin
        src_ready = '0;
        winc_d    = 1'b0;
        wdata_d   = wdata_q;
        case (state_q)
            ST_HEADER: begin
                if (hdr_wr) begin
                    winc_d  = 1'b1;
                    wdata_d = make_header(grant_id_q, seq_q);
                end
            end
            ST_BURST: begin
                for (int i = 0; i < NUM_SRC; i++)
                    src_ready[i] = (grant_id_q == ID_W'(i)) && !bus.fifo_afull;
                if (accept) begin
                    winc_d  = 1'b1;
                    wdata_d = sel_data;
                end
            end
`ifdef SCHED_CHECKSUM_EN
            ST_TRAILER: begin
                if (trl_wr) begin
                    winc_d  = 1'b1;
                    wdata_d = sum_q;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) begin
            winc_q       <= 1'b0;
            wdata_q      <= '0;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_SRC - 1);
            seq_q        <= '0;
            beat_q       <= '0;
            drop_cnt_q   <= '0;
            ovf_err_q    <= 1'b0;
        end else begin
            winc_q  <= winc_d;
            wdata_q <= wdata_d;
            if (arb_go)    grant_id_q   <= arb_id;
            if (last_beat) last_grant_q <= grant_id_q;
            if (hdr_wr) begin
                seq_q  <= seq_q + 1'b1;
                beat_q <= '0;
            end else if (accept) begin
                beat_q <= beat_q + 1'b1;
            end
            if (drop_any && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
            if (winc_q && bus.fifo_full)            ovf_err_q  <= 1'b1;
        end
    end

`ifdef SCHED_CHECKSUM_EN
    always_ff @(posedge clk_data or posedge rst) begin
        if (rst)         sum_q <= '0;
        else if (hdr_wr) sum_q <= '0;
        else if (accept) sum_q <= sum_q + sel_data;
    end
`endif

    assign bus.src_ready  = src_ready;
    assign bus.fifo_winc  = winc_q;
    assign bus.fifo_wdata = wdata_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_hsdaoh_fifo_scheduler.sv
// Self-checking bench for hsdaoh_fifo_scheduler: scoreboard of expected FIFO
// words plus table-driven scenarios and hand-written corner sequences.
module tb_hsdaoh_fifo_scheduler;

    localparam int NUM_SRC   = 2;
    localparam int BURST_LEN = 4;
`ifdef SCHED_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int PERIOD    = BURST_LEN + 2 + CK;
    localparam int BURST_WRS = BURST_LEN + 1 + CK;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hsdaoh_fifo_scheduler_if #(.NUM_SRC(NUM_SRC)) bus ();

    hsdaoh_fifo_scheduler #(.NUM_SRC(NUM_SRC), .BURST_LEN(BURST_LEN)) dut (
        .clk_data (clk),
        .rst      (rst),
        .bus      (bus.master)
    );

    typedef struct {
        string              name;
        logic [NUM_SRC-1:0] valid;
        logic               en;
        int                 cycles;
        int                 writes;
        int                 drops;
    } vec_t;

    int                 n_cmp = 0;
    int                 n_fail = 0;
    logic [15:0]        exp_q[$];
    logic [15:0]        wlog[$];
    int                 writes;
    logic [15:0]        base[NUM_SRC];
    int unsigned        cnt[NUM_SRC];
    logic [NUM_SRC-1:0] acc;
    vec_t               vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One clock: drive source data, note handshakes, then compare the write.
    task automatic step();
        for (int i = 0; i < NUM_SRC; i++)
            bus.src_data[16*i +: 16] = base[i] + 16'(cnt[i]);
        #1;
        acc = bus.src_valid & bus.src_ready;
        @(negedge clk);
        if (bus.fifo_winc === 1'b1) begin
            writes++;
            wlog.push_back(bus.fifo_wdata);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL extra_write: got %h, expected no write", bus.fifo_wdata);
            end else begin
                check("fifo_wdata", {16'h0, bus.fifo_wdata}, {16'h0, exp_q.pop_front()});
            end
        end
        for (int i = 0; i < NUM_SRC; i++)
            if (acc[i]) cnt[i]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.src_valid  = '0;
        bus.src_data   = '0;
        bus.fifo_afull = 1'b0;
        bus.fifo_full  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) cnt[i] = 0;
        exp_q.delete();
        wlog.delete();
        writes = 0;
        acc    = '0;
        #2;
        check("rst_winc",  32'(bus.fifo_winc),  32'h0);
        check("rst_wdata", 32'(bus.fifo_wdata), 32'h0);
        check("rst_ready", 32'(bus.src_ready),  32'h0);
        check("rst_grant", 32'(bus.grant_id),   32'h0);
        check("rst_drop",  32'(bus.drop_cnt),   32'h0);
        check("rst_ovf",   32'(bus.ovf_err),    32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model of the write stream: headers, payload, optional trailer.
    task automatic push_stream(input logic [NUM_SRC-1:0] mask, input int bursts);
        int          last;
        int          seq;
        int          g;
        bit          found;
        int          m[NUM_SRC];
        logic [15:0] d;
        logic [15:0] sum;
        last = NUM_SRC - 1;
        seq  = 0;
        for (int i = 0; i < NUM_SRC; i++) m[i] = 0;
        if (mask == '0) return;
        for (int b = 0; b < bursts; b++) begin
            found = 1'b0;
            g     = 0;
            for (int k = 1; k <= NUM_SRC; k++)
                if (!found && mask[(last + k) % NUM_SRC]) begin
                    g     = (last + k) % NUM_SRC;
                    found = 1'b1;
                end
            exp_q.push_back({4'hA, 4'(g), 8'(seq)});
            sum = '0;
            for (int w = 0; w < BURST_LEN; w++) begin
                d = base[g] + 16'(m[g]);
                m[g]++;
                exp_q.push_back(d);
                sum = sum + d;
            end
            if (CK != 0) exp_q.push_back(sum);
            seq  = (seq + 1) % 256;
            last = g;
        end
    endtask

    // Writes latched by clock edges 1..r with continuous traffic from edge 1.
    function automatic int exp_writes(input int r);
        int c = 0;
        for (int p = 2; p <= r; p++)
            if ((p - 2) % PERIOD != PERIOD - 1) c++;
        return c;
    endfunction

    function automatic int exp_accepts(input int r);
        int c = 0;
        for (int p = 2; p <= r; p++)
            if ((p - 2) % PERIOD >= 1 && (p - 2) % PERIOD <= BURST_LEN) c++;
        return c;
    endfunction

    initial begin
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.src_valid  = '0;
        bus.src_data   = '0;
        bus.fifo_afull = 1'b0;
        bus.fifo_full  = 1'b0;
        base[0] = 16'h1000;
        base[1] = 16'h2000;

        vecs[0] = '{"both_rr",   2'b11, 1'b1, 30, exp_writes(30), 30};
        vecs[1] = '{"src1_only", 2'b10, 1'b1, 30, exp_writes(30), 30 - exp_accepts(30)};
        vecs[2] = '{"src0_only", 2'b01, 1'b1, 25, exp_writes(25), 25 - exp_accepts(25)};
        vecs[3] = '{"no_valid",  2'b00, 1'b1, 12, 0, 0};
        vecs[4] = '{"disabled",  2'b11, 1'b0, 12, 0, 12};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            base[0]       = 16'h1000;
            base[1]       = 16'h2000;
            bus.enable    = vecs[v].en;
            bus.src_valid = vecs[v].valid;
            if (vecs[v].en) push_stream(vecs[v].valid, 8);
            repeat (vecs[v].cycles) step();
            check({vecs[v].name, "_writes"}, 32'(writes), 32'(vecs[v].writes));
            check({vecs[v].name, "_drops"},  32'(bus.drop_cnt), 32'(vecs[v].drops));
        end

        // Almost-full stall in the middle of a burst
        do_reset();
        base[0]       = 16'h3000;
        bus.enable    = 1'b1;
        bus.src_valid = 2'b01;
        push_stream(2'b01, 3);
        repeat (4) step();
        bus.fifo_afull = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("stall_winc",  32'(bus.fifo_winc), 32'h0);
            check("stall_ready", 32'(bus.src_ready), 32'h0);
        end
        bus.fifo_afull = 1'b0;
        for (int k = 0; k < 40 && writes < 2 * BURST_WRS; k++) step();
        check("stall_total", 32'(writes), 32'(2 * BURST_WRS));

        // Write while full sets a sticky error
        do_reset();
        base[0]       = 16'h4000;
        bus.enable    = 1'b1;
        bus.src_valid = 2'b01;
        bus.fifo_full = 1'b1;
        push_stream(2'b01, 4);
        repeat (2) step();
        check("ovf_before", 32'(bus.ovf_err), 32'h0);
        step();
        check("ovf_set", 32'(bus.ovf_err), 32'h1);
        bus.fifo_full = 1'b0;
        repeat (10) step();
        check("ovf_sticky", 32'(bus.ovf_err), 32'h1);

        // 258 bursts: header sequence wraps FF -> 00
        do_reset();
        base[0]       = 16'h5000;
        bus.enable    = 1'b1;
        bus.src_valid = 2'b01;
        push_stream(2'b01, 258);
        for (int k = 0; k < 258 * PERIOD + 10 && writes < 258 * BURST_WRS; k++) step();
        check("wrap_writes", 32'(writes), 32'(258 * BURST_WRS));
        check("wrap_hdr_ff", 32'(wlog[255 * BURST_WRS]), 32'h0000A0FF);
        check("wrap_hdr_00", 32'(wlog[256 * BURST_WRS]), 32'h0000A000);

        // Reset in the middle of a burst, then payload 1,2,3,4
        do_reset();
        base[0]       = 16'h0001;
        bus.enable    = 1'b1;
        bus.src_valid = 2'b01;
        push_stream(2'b01, 2);
        repeat (4) step();
        do_reset();
        base[0]       = 16'h0001;
        bus.enable    = 1'b1;
        bus.src_valid = 2'b01;
        push_stream(2'b01, 2);
        repeat (PERIOD) step();
        check("post_rst_hdr", 32'(wlog[0]), 32'h0000A000);
        check("post_rst_pl3", 32'(wlog[BURST_LEN]), 32'h00000004);
`ifdef SCHED_CHECKSUM_EN
        check("trailer_sum", 32'(wlog[BURST_LEN + 1]), 32'h0000000A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hsdaoh_fifo_scheduler.md
# hsdaoh_fifo_scheduler

Round-robin write scheduler sitting between the sample producers (1-bit SDR accumulator, test-pattern generator, future ADC front-ends) and the write port of the hsdaoh async FIFO in the `clk_data` domain. It grants the FIFO to one source at a time for fixed-length bursts and prefixes every burst with a header word so the host can demultiplex the stream. It also applies backpressure from FIFO almost-full and counts dropped samples.

## Interface
- `NUM_SRC`, 2: number of requesters, 1..16.
- `BURST_LEN`, 256: payload words per burst, 2..65535.
- `clk_data`  in  1: sample clock; all logic runs on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: scheduling allowed; sampled only in ARB.
- `src_valid`  in  NUM_SRC: per-source word available.
- `src_data`  in  16*NUM_SRC: source i occupies bits [16i+15:16i].
- `src_ready`  out  NUM_SRC: per-source accept; combinational.
- `fifo_afull`  in  1: FIFO almost-full (awfull).
- `fifo_full`  in  1: FIFO full, error detection only.
- `fifo_winc`  out  1: FIFO write strobe, registered.
- `fifo_wdata`  out  16: FIFO write data, registered.
- `grant_id`  out  4: currently granted source.
- `drop_cnt`  out  16: saturating dropped-sample counter.
- `ovf_err`  out  1: sticky write-while-full flag.

## Operation
- States: ARB, HEADER, BURST, plus TRAILER when `SCHED_CHECKSUM_EN` is defined.
- ARB:
  - If `enable` is high, `fifo_afull` is low, and any `src_valid` is high, grant the first valid source searching from `last_grant+1` modulo NUM_SRC.
  - Latch the granted index into `grant_id` and go to HEADER. Otherwise stay in ARB.
- HEADER:
  - If `fifo_afull` is low, write header `{4'hA, grant_id, seq[7:0]}`, increment `seq` (wraps 255→0), clear `beat`, and go to BURST.
  - If `fifo_afull` is high, wait in HEADER.
- BURST:
  - `src_ready[grant_id] = !fifo_afull`; all other ready bits are 0.
  - Each `valid & ready` cycle writes the source word and increments `beat`.
  - On acceptance with `beat == BURST_LEN-1`, set `last_grant = grant_id` and go to ARB (or to TRAILER if the checksum is compiled in).
  - A gap in the granted source's valid stalls the burst indefinitely.
  - Deasserting `enable` mid-burst does not abort the burst.
- Drops:
  - Any cycle with `src_valid[i] & !src_ready[i]` for at least one i increments `drop_cnt` by 1.
  - The increment is one per cycle regardless of how many sources drop.
  - `drop_cnt` saturates at 16'hFFFF.
- Overflow:
  - `fifo_winc & fifo_full` in the same cycle sets `ovf_err`.
  - `ovf_err` is cleared only by `rst`.
- Reset mid-burst: immediate return to ARB; the partial burst is not completed.
- Reset values:
  - `fifo_winc`=0, `fifo_wdata`=0, `src_ready`=0, `grant_id`=0, `drop_cnt`=0, `ovf_err`=0.
  - `seq`=0, `last_grant`=NUM_SRC-1, so source 0 wins first.

## Timing
- Accept-to-write latency is 1 cycle: `fifo_winc`/`fifo_wdata` are registered from the acceptance cycle.
- Throughput is 1 word/cycle in BURST.
- Per-burst overhead is 2 cycles (ARB + HEADER), plus 1 cycle for TRAILER when compiled in.
- `fifo_afull` must assert at least 2 entries before full. Backpressure takes effect in the same cycle through combinational `src_ready`.
- A burst of L words from grant to last write takes L+2 cycles when unstalled.

## Configuration
- `SCHED_CHECKSUM_EN` defined:
  - TRAILER state after BURST waits for `!fifo_afull`, then writes the 16-bit wrapping sum of all payload words of the burst, then goes to ARB.
  - The sum is cleared in HEADER.
- Undefined: no TRAILER state, no sum register; BURST goes directly to ARB.

## Structure
- Package `hsdaoh_sched_pkg` holds:
  - the state enum;
  - `HDR_MAGIC = 4'hA`;
  - the header field widths (magic 4, id 4, seq 8);
  - `DATA_W = 16`.
- Sub-module `rr_arbiter`: combinational round-robin priority search taking `req[NUM_SRC]` and `last` and returning `gnt_id` and `any`.

## Test plan
- NUM_SRC=2, BURST_LEN=4, both sources always valid with data 16'h1000+n / 16'h2000+n:
  - FIFO sees A000, 4×src0 words, A101, 4×src1 words, A002, and so on.
  - `drop_cnt` increments every cycle.
- Only src1 valid, `enable`=1: first header is A100.
  - Round-robin never grants idle src0.
- `fifo_afull` held high for 10 cycles mid-burst:
  - no `fifo_winc` during those cycles, `src_ready` is 0;
  - the burst resumes after release with no lost or duplicated words.
- Force `fifo_full`=1 with `fifo_winc`=1: `ovf_err` goes to 1 and stays 1 until `rst`.
- Run 257 bursts: the header seq field wraps FF→00.
- With `SCHED_CHECKSUM_EN` and payload 1,2,3,4: the trailer word is 16'h000A.
  - Assert `rst` mid-burst: outputs return to reset values; the next header carries seq 00.
